// File: rtl/exe_muldiv_pkg.sv
// Shared types and constants for the sequential RV32M multiply/divide unit.
package exe_muldiv_pkg;

   localparam int ITER_DEFAULT = 32;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/exe_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and emit one quotient bit.
module exe_div_step #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] rem,
   input  logic [DATA_WIDTH-1:0] quo,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic [DATA_WIDTH-1:0] rem_next,
   output logic [DATA_WIDTH-1:0] quo_next
);

   logic [DATA_WIDTH:0]   shifted;
   logic [DATA_WIDTH-1:0] trial;
   logic                  fits;

   assign shifted  = {rem, quo[DATA_WIDTH-1]};
   assign fits     = shifted >= {1'b0, divisor};
   // Only used when fits, so the result is known to be below 2^DATA_WIDTH.
   assign trial    = shifted[DATA_WIDTH-1:0] - divisor;
   assign rem_next = fits ? trial : shifted[DATA_WIDTH-1:0];
   assign quo_next = {quo[DATA_WIDTH-2:0], fits};

endmodule

// File: rtl/exe_muldiv_seq.sv
// Sequential RV32M multiply/divide unit for the EXE stage (shift-add multiply,
// restoring divide). Define EXE_MULDIV_FAST_MUL_EN for single-cycle multiplies.
import exe_muldiv_pkg::*;

module exe_muldiv_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int ITER       = ITER_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] rs1_data,
   input  logic [DATA_WIDTH-1:0] rs2_data,
   input  logic                  flush,
   output logic                  stall_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] result_o
);

   localparam int W = DATA_WIDTH;

   state_t         state;
   logic [5:0]     cnt;
   logic [2:0]     op;
   logic           neg_a;
   logic           neg_b;
   logic [W-1:0]   opb;
   logic [2*W-1:0] acc;

   logic           sign_a, sign_b, in_neg_a, in_neg_b;
   logic [W-1:0]   mag_a, mag_b;
   logic           div_zero, div_ovf;
   logic [W-1:0]   special;
   logic [W-1:0]   addend;
   logic [W:0]     hi_sum;
   logic [2*W-1:0] mul_next;
   logic [W-1:0]   rem_next, quo_next;
   logic [2*W-1:0] div_next;

   // Sign fix-up and result-word selection, applied as the op enters DONE.
   function automatic logic [W-1:0] fixup(input logic [2:0] f, input logic na,
                                          input logic nb, input logic [2*W-1:0] val);
      logic [2*W-1:0] prod;
      logic [W-1:0]   q;
      logic [W-1:0]   r;
      prod = (na ^ nb) ? -val : val;
      q    = (na ^ nb) ? -(val[W-1:0]) : val[W-1:0];
      r    = na ? -(val[2*W-1:W]) : val[2*W-1:W];
      case (f)
         F3_MUL:                      return prod[W-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: return prod[2*W-1:W];
         F3_DIV, F3_DIVU:              return q;
         default:                      return r;
      endcase
   endfunction

   assign sign_a   = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                     (funct3 == F3_DIV)  || (funct3 == F3_REM);
   assign sign_b   = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
   assign in_neg_a = sign_a & rs1_data[W-1];
   assign in_neg_b = sign_b & rs2_data[W-1];
   assign mag_a    = in_neg_a ? -rs1_data : rs1_data;
   assign mag_b    = in_neg_b ? -rs2_data : rs2_data;

   assign div_zero = funct3[2] && (rs2_data == '0);
   assign div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                     (rs1_data == {1'b1, {(W-1){1'b0}}}) && (rs2_data == {W{1'b1}});
   // funct3[1] separates REM/REMU from DIV/DIVU.
   assign special  = div_zero ? (funct3[1] ? rs1_data : {W{1'b1}})
                              : (funct3[1] ? {W{1'b0}} : rs1_data);

   // Multiply: acc = {partial product, remaining multiplier bits}.
   assign addend   = acc[0] ? opb : {W{1'b0}};
   assign hi_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, addend};
   assign mul_next = {hi_sum, acc[W-1:1]};

   // Divide: acc = {partial remainder, dividend/quotient shift register}.
   exe_div_step #(.DATA_WIDTH(W)) u_div_step (
      .rem      (acc[2*W-1:W]),
      .quo      (acc[W-1:0]),
      .divisor  (opb),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );
   assign div_next = {rem_next, quo_next};

`ifdef EXE_MULDIV_FAST_MUL_EN
   logic [2*W-1:0] fast_prod;
   assign fast_prod = {{W{1'b0}}, mag_a} * {{W{1'b0}}, mag_b};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         op       <= '0;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         opb      <= '0;
         acc      <= '0;
         result_o <= '0;
      end else if (flush) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               op    <= funct3;
               neg_a <= in_neg_a;
               neg_b <= in_neg_b;
               cnt   <= '0;
               if (div_zero || div_ovf) begin
                  result_o <= special;
                  state    <= ST_DONE;
               end else if (funct3[2]) begin
                  acc   <= {{W{1'b0}}, mag_a};
                  opb   <= mag_b;
                  state <= ST_DIV;
               end
`ifdef EXE_MULDIV_FAST_MUL_EN
               else begin
                  result_o <= fixup(funct3, in_neg_a, in_neg_b, fast_prod);
                  state    <= ST_DONE;
               end
`else
               else begin
                  acc   <= {{W{1'b0}}, mag_b};
                  opb   <= mag_a;
                  state <= ST_MUL;
               end
`endif
            end
            ST_MUL: begin
               acc <= mul_next;
               cnt <= cnt + 6'd1;
               if (cnt == 6'(ITER - 1)) begin
                  result_o <= fixup(op, neg_a, neg_b, mul_next);
                  state    <= ST_DONE;
               end
            end
            ST_DIV: begin
               acc <= div_next;
               cnt <= cnt + 6'd1;
               if (cnt == 6'(ITER - 1)) begin
                  result_o <= fixup(op, neg_a, neg_b, div_next);
                  state    <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
         endcase
      end
   end

   assign busy_o  = (state != ST_IDLE);
   assign stall_o = ((state == ST_IDLE) && start && !flush) ||
                    (state == ST_MUL) || (state == ST_DIV);
   assign done_o  = (state == ST_DONE) && !flush;

endmodule
